// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and TX output-mux select codes
// Purpose: one place for the frame-sequencer state encoding and the select
//          codes that the sequencer drives and the TX output mux decodes.
// Ports:   none (package).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Output-mux select codes: START drives 0, STOP/IDLE drives 1,
  // DATA drives the serializer bit, PAR drives the parity bit.
  localparam logic [1:0] MUX_START = 2'd0;
  localparam logic [1:0] MUX_STOP  = 2'd1;
  localparam logic [1:0] MUX_DATA  = 2'd2;
  localparam logic [1:0] MUX_PAR   = 2'd3;

endpackage

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame sequencer (START, DATA, PARITY, STOP)
// Purpose: accepts a byte handshake and steps the TX datapath through one
//          frame. Owns BUSY; no data passes through this block.
// Ports:
//   CLK        in  clock, rising edge
//   RST        in  asynchronous active-low reset
//   Data_Valid in  host strobe, frame data present on the datapath bus
//   PAR_EN     in  parity enable, sampled only when a frame is accepted
//   Ser_Done   in  serializer last-bit flag, cross-checked against cnt
//   Ser_Load   out serializer load pulse (combinational, IDLE & Data_Valid)
//   Ser_En     out serializer shift enable, high in every DATA cycle
//   Mux_Sel    out TX mux select (see uart_tx_pkg)
//   BUSY       out frame in progress, first START cycle to last STOP cycle
//   Frame_Err  out sticky Ser_Done/bit-count disagreement, cleared by reset
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       Ser_Done,
  output logic       Ser_Load,
  output logic       Ser_En,
  output logic [1:0] Mux_Sel,
  output logic       BUSY,
  output logic       Frame_Err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          par_en_q;
  logic          last_bit;

  assign last_bit = (cnt == LAST);

  // Gated by RST so no load pulse escapes while reset holds the block in IDLE.
  assign Ser_Load = RST & (state == IDLE) & Data_Valid;

  // Outputs are loaded together with the state they belong to, so they are
  // registered yet always consistent with the current state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      Ser_En    <= 1'b0;
      Mux_Sel   <= MUX_STOP;
      BUSY      <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            state    <= START;
            par_en_q <= PAR_EN;
            cnt      <= '0;
            Mux_Sel  <= MUX_START;
            BUSY     <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          Mux_Sel <= MUX_DATA;
          Ser_En  <= 1'b1;
        end
        DATA: begin
          // The sequence is paced by the internal count only; Ser_Done is
          // just checked, never waited on.
          if (Ser_Done != last_bit) Frame_Err <= 1'b1;
          if (last_bit) begin
            Ser_En <= 1'b0;
            if (par_en_q) begin
              state   <= PARITY;
              Mux_Sel <= MUX_PAR;
            end else begin
              state   <= STOP;
              Mux_Sel <= MUX_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          state   <= STOP;
          Mux_Sel <= MUX_STOP;
        end
        STOP: begin
          state   <= IDLE;
          Mux_Sel <= MUX_STOP;
          BUSY    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Ser_En  <= 1'b0;
          Mux_Sel <= MUX_STOP;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - self-checking bench for uart_tx_fsm
module tb_uart_tx_fsm;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       Ser_Done = 1'b0;
  logic       Ser_Load;
  logic       Ser_En;
  logic [1:0] Mux_Sel;
  logic       BUSY;
  logic       Frame_Err;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .Ser_Done  (Ser_Done),
    .Ser_Load  (Ser_Load),
    .Ser_En    (Ser_En),
    .Mux_Sel   (Mux_Sel),
    .BUSY      (BUSY),
    .Frame_Err (Frame_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       dv;
    logic       par;
    logic       sd;
    logic       ld;
    logic       en;
    logic [1:0] mux;
    logic       busy;
    logic       err;
    int         tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ld_seen = 0;
  logic exp_err = 1'b0;
  int   cur_tag = 0;

  task automatic push(input logic rst, input logic dv, input logic par, input logic sd,
                      input logic ld, input logic en, input logic [1:0] mux, input logic busy);
    vec_t v;
    v.rst = rst; v.dv = dv; v.par = par; v.sd = sd;
    v.ld = ld; v.en = en; v.mux = mux; v.busy = busy;
    if (!rst) exp_err = 1'b0;
    v.err = exp_err;
    v.tag = cur_tag;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1, 0, 0, 0, 0, 0, 2'd1, 0);
  endtask

  // One frame from the accept cycle through STOP. flip_at: first DATA index
  // from which PAR_EN is inverted; early_at: DATA index with a spurious
  // Ser_Done; abort_at: DATA index in which RST is pulsed.
  task automatic add_frame(input logic par, input logic hold, input int flip_at,
                           input int early_at, input int abort_at);
    logic pf;
    logic sd;
    push(1, 1, par, 0, 1, 0, 2'd1, 0);
    push(1, hold, par, 0, 0, 0, 2'd0, 1);
    pf = par;
    for (int i = 0; i < W; i++) begin
      if (i == flip_at) pf = ~par;
      if (i == abort_at) begin
        push(0, hold, pf, 0, 0, 0, 2'd1, 0);
        push(1, 0, 0, 0, 0, 0, 2'd1, 0);
        return;
      end
      sd = (i == W - 1) || (i == early_at);
      push(1, hold, pf, sd, 0, 1, 2'd2, 1);
      if (sd != (i == W - 1)) exp_err = 1'b1;
    end
    if (par) push(1, hold, pf, 0, 0, 0, 2'd3, 1);
    push(1, hold, pf, 0, 0, 0, 2'd1, 1);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      checks++;
      if (Ser_Load !== e.ld || Ser_En !== e.en || Mux_Sel !== e.mux ||
          BUSY !== e.busy || Frame_Err !== e.err) begin
        failures++;
        $display("FAIL test%0d_cycle t=%0t got ld=%b en=%b mux=%0d busy=%b err=%b exp ld=%b en=%b mux=%0d busy=%b err=%b",
                 e.tag, $time, Ser_Load, Ser_En, Mux_Sel, BUSY, Frame_Err,
                 e.ld, e.en, e.mux, e.busy, e.err);
      end
      if (Ser_Load === 1'b1) ld_seen++;
    end
  end

  initial begin
    // 1: reset held with Data_Valid high
    cur_tag = 1;
    for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 0, 0, 2'd1, 0);
    add_idle(2);
    // 2: plain frame, no parity
    cur_tag = 2;
    add_frame(0, 0, -1, -1, -1);
    add_idle(2);
    // 3: parity frame, PAR_EN dropped at DATA cycle 3
    cur_tag = 3;
    add_frame(1, 0, 2, -1, -1);
    add_idle(1);
    // 4: Data_Valid held high, back-to-back frames every 11 cycles
    cur_tag = 4;
    for (int f = 0; f < 4; f++) add_frame(0, 1, -1, -1, -1);
    add_idle(2);
    // 5: reset in DATA cycle 4, then a fresh frame
    cur_tag = 5;
    add_frame(0, 0, -1, -1, 3);
    add_idle(1);
    add_frame(1, 0, -1, -1, -1);
    add_idle(1);
    // 6: early Ser_Done at DATA cycle 5, error sticks across later frames
    cur_tag = 6;
    add_frame(0, 0, -1, 4, -1);
    add_idle(2);
    add_frame(0, 0, -1, -1, -1);
    add_idle(1);
    cur_tag = 7;
    push(0, 0, 0, 0, 0, 0, 2'd1, 0);
    add_idle(2);

    foreach (vecs[k]) begin
      @(posedge CLK);
      #1;
      RST        = vecs[k].rst;
      Data_Valid = vecs[k].dv;
      PAR_EN     = vecs[k].par;
      Ser_Done   = vecs[k].sd;
      sb.push_back(vecs[k]);
    end
    @(negedge CLK);
    #1;

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    // 1 + 1 + 4 + (aborted + fresh) + 2 frames
    checks++;
    if (ld_seen != 10) begin
      failures++;
      $display("FAIL ser_load_count got=%0d exp=10", ld_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
